// File: rtl/timer_pkg.sv
// timer_pkg: shared widths, clock-select encodings and TCR bit positions for the timer core.
package timer_pkg;
    localparam int TMR_CNT_W = 8;
    localparam int TMR_PSC_W = 4;
    localparam logic [1:0] CKS_DIV2  = 2'b00;
    localparam logic [1:0] CKS_DIV4  = 2'b01;
    localparam logic [1:0] CKS_DIV8  = 2'b10;
    localparam logic [1:0] CKS_DIV16 = 2'b11;
    localparam int TCR_LOAD   = 7;
    localparam int TCR_UPDOWN = 5;
    localparam int TCR_EN     = 4;

    function automatic logic [TMR_PSC_W-1:0] cks_to_mask(input logic [1:0] cks);
        return cks == CKS_DIV2 ? TMR_PSC_W'(1) :
               cks == CKS_DIV4 ? TMR_PSC_W'(3) :
               cks == CKS_DIV8 ? TMR_PSC_W'(7) : TMR_PSC_W'(15);
    endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider that emits a one-pclk tick every 2/4/8/16 pclk.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PSC_W = TMR_PSC_W
) (
    input  logic       pclk_i,
    input  logic       presetn_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [1:0] cks_i,
    output logic       tick_o
);
    logic [PSC_W-1:0] psc_q, psc_d, mask;
    logic             run;

    // The counter is not cleared on a cks change, so the new mask applies immediately.
    always_comb begin
        run    = en_i & ~clr_i;
        mask   = PSC_W'(cks_to_mask(cks_i));
        psc_d  = run ? psc_q + PSC_W'(1) : '0;
        tick_o = run & ((psc_q & mask) == mask);
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) psc_q <= '0;
        else            psc_q <= psc_d;
    end
endmodule

// File: rtl/timer_counter_core.sv
// timer_counter_core: loadable up/down counter with registered tick and wrap pulses.
module timer_counter_core
    import timer_pkg::*;
#(
    parameter int CNT_W = TMR_CNT_W,
    parameter int PSC_W = TMR_PSC_W
) (
    input  logic             pclk_i,
    input  logic             presetn_i,
    input  logic [CNT_W-1:0] tdr_val_i,
    input  logic             load_i,
    input  logic             updown_i,
    input  logic             en_i,
    input  logic [1:0]       cks_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_tick_o,
    output logic             ovf_set_o,
    output logic             udf_set_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, ovf_q, udf_q;
    logic             ovf_d, udf_d, tick;

    timer_prescaler #(.PSC_W(PSC_W)) u_psc (
        .pclk_i   (pclk_i),
        .presetn_i(presetn_i),
        .en_i     (en_i),
        .clr_i    (load_i),
        .cks_i    (cks_i),
        .tick_o   (tick)
    );

    // tick is already gated by load, so load alone decides precedence over counting.
    always_comb begin
        cnt_d = load_i ? tdr_val_i :
                tick   ? (updown_i ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1)) : cnt_q;
        ovf_d = tick & ~updown_i & (cnt_q == '1);
        udf_d = tick &  updown_i & (cnt_q == '0);
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_tick_o = tick_q;
    assign ovf_set_o  = ovf_q;
    assign udf_set_o  = udf_q;
endmodule
